roi_capture_ctrl: RTL and testbench
===================================

Name: roi_capture_ctrl

Overview:
Sequences single-frame captures of the binarized 112x112 region of interest (ROI) for the CNN classifier.
- On a capture request it arms, then waits for the next frame boundary.
- It consumes the bin_data/bin_data_vld stream from the camera front end and 4x4-pools it to a 28x28 binary image by majority threshold.
- It writes the image row-major into the CNN input RAM, then holds cap_done until the CNN acknowledges.
- It sits between the camera front end and the CNN input buffer, and is the only writer of that buffer.

Parameters:
ROI_W, 112, ROI width in pixels; must be a multiple of POOL
ROI_H, 112, ROI height in lines; must be a multiple of POOL
POOL, 4, pooling factor; power of two
POOL_THR, 8, output pixel is 1 when the count of ones in a POOLxPOOL block is >= POOL_THR
ADDR_W, 10, RAM address width; 2^ADDR_W must be >= (ROI_W/POOL)*(ROI_H/POOL)

Ports:
camera_pclk  in  1  sole clock
s_rst_n  in  1  reset; synchronous, active-low
camera_vs  in  1  sensor vertical sync; high during vertical blanking
bin_data  in  1  binarized ROI pixel, 1 = foreground
bin_data_vld  in  1  bin_data is an ROI pixel; ROI_W contiguous cycles per line
cap_req  in  1  CNN requests one capture; level, sampled only in IDLE
cap_ack  in  1  CNN has consumed the image; sampled only in DONE
cap_busy  out  1  high in ARM and CAPTURE
cap_done  out  1  high in DONE
cap_err  out  1  one-cycle pulse on short frame
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM address, 0..783
wr_data  out  1  pooled pixel

Behaviour:
- All flops are synchronous to camera_pclk; s_rst_n low at a clock edge forces the following:
  - state = IDLE; all counters and accumulators = 0.
  - Every output = 0 from that edge. This applies mid-capture as well; there is no partial-frame resume.
- Frame events:
  - camera_vs is registered once.
  - frame_start = the cycle in which the registered value is 1 and the current camera_vs is 0 (falling edge).
  - frame_end = rising edge, detected the same way.
- FSM:
  - IDLE: when cap_req = 1, go to ARM.
  - ARM: on frame_start, clear the pixel counter (px 0..ROI_W-1), the line counter (ln 0..ROI_H-1) and wr_addr, then go to CAPTURE. bin_data_vld is ignored in ARM, so a request arriving mid-frame waits for the next full frame.
  - CAPTURE: process each vld cycle as described under "Pooling" below.
    - After the write for the last block (ln = ROI_H-1, px = ROI_W-1), go to DONE.
    - If frame_end occurs before that write, pulse cap_err for 1 cycle and return to ARM (automatic retry).
  - DONE: when cap_ack = 1, go to IDLE. cap_req is ignored in DONE. cap_ack outside DONE is ignored.
- Pooling (per vld cycle in CAPTURE):
  - bc = px / POOL (block column, 0..27).
  - acc is an array of ROI_W/POOL entries, each $clog2(POOL*POOL+1) bits wide (5 bits at default).
  - First pixel of a block (ln%POOL = 0 and px%POOL = 0): acc[bc] = bin_data. Otherwise: acc[bc] = acc[bc] + bin_data.
  - Last pixel of a block (ln%POOL = POOL-1 and px%POOL = POOL-1):
    - wr_data = ((acc[bc] + bin_data) >= POOL_THR). The comparison uses the sum before it is stored.
    - wr_en = 1 on the next cycle (latency 1).
  - After each write, wr_addr increments by 1 (running counter, no multiplier). Write order is row-major, addresses 0..783.
  - px wraps to 0 after ROI_W-1, and ln increments at that point.
- Output timing:
  - cap_done rises on the cycle after the write with wr_addr = 783.
  - wr_en is never asserted outside CAPTURE, except for the final write, which lands on the cycle DONE is entered.
- Boundary cases:
  - Gaps in vld within a line are tolerated; only vld cycles advance px.
  - Extra vld cycles after the last block, while still in the same frame, are ignored once in DONE.
  - frame_end in the same cycle as the last vld pixel: the final write still completes and the FSM goes to DONE with no cap_err. Completion takes priority.

Decomposition:
- Shared package roi_cap_pkg holds:
  - the state enum (IDLE, ARM, CAPTURE, DONE);
  - localparams OUT_W = ROI_W/POOL, OUT_H = ROI_H/POOL, NPIX = OUT_W*OUT_H, ACC_W.
- One sub-module is natural: roi_pool_acc, containing the accumulator array, the threshold compare and the write-strobe register.
  - It is driven by vld, bin_data, px and ln from the parent.
  - The FSM, vsync edge detection and counters stay in roi_capture_ctrl.

Test Plan:
1. Reset, cap_req = 1, then a full frame with all bin_data = 1 -> 784 wr_en pulses with addresses 0..783 in order, all wr_data = 1. cap_done rises 1 cycle after address 783; cap_ack returns the FSM to IDLE and clears cap_done.
2. Threshold boundary: block 0 has 8 ones, block 1 has 7 ones, the rest are 0 -> wr_data = 1 at address 0, 0 at address 1 and 0 elsewhere. With POOL_THR = 16, full blocks give 1 and a block with 15 ones gives 0.
3. Request asserted mid-frame (line 50) -> no writes in that frame. Capture begins at the next camera_vs falling edge, and the first write comes from that frame's block 0.
4. Short frame (camera_vs rises after 60 ROI lines) -> cap_err high for exactly 1 cycle, no cap_done, state returns to ARM. The next full frame completes with 784 writes, wr_addr restarting at 0.
5. Frames run continuously with cap_req = 0 -> zero writes, and cap_busy and cap_done stay 0. In DONE, toggling cap_req without cap_ack produces no new writes.
6. s_rst_n pulsed low during CAPTURE at line 40 -> every output is 0 on the next cycle. A subsequent request captures a clean, full 784-pixel frame.

Source files
------------

// File: rtl/roi_cap_pkg.sv
// roi_cap_pkg: shared types and default geometry for the ROI capture block.
//   - cap_state_e : capture sequencer states
//   - DEF_*       : default ROI geometry / threshold / RAM address width
//   - OUT_W/OUT_H/NPIX/ACC_W : pooled image geometry at the default config
package roi_cap_pkg;

    localparam int DEF_ROI_W    = 112;
    localparam int DEF_ROI_H    = 112;
    localparam int DEF_POOL     = 4;
    localparam int DEF_POOL_THR = 8;
    localparam int DEF_ADDR_W   = 10;

    localparam int OUT_W = DEF_ROI_W / DEF_POOL;
    localparam int OUT_H = DEF_ROI_H / DEF_POOL;
    localparam int NPIX  = OUT_W * OUT_H;
    localparam int ACC_W = $clog2(DEF_POOL * DEF_POOL + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_e;

    // Accumulator width able to hold a full POOLxPOOL count of ones.
    function automatic int acc_width(input int pool);
        return $clog2(pool * pool + 1);
    endfunction

endpackage

// File: rtl/roi_pool_acc.sv
// roi_pool_acc: per-block-column ones counters for POOLxPOOL majority pooling.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   vld_i, bin_data_i   : qualified ROI pixel from the parent sequencer
//   px_i, ln_i          : pixel / line position of the current pixel
//   wr_en_o, wr_data_o  : registered write strobe and pooled pixel (latency 1)
module roi_pool_acc
    import roi_cap_pkg::*;
#(
    parameter int ROI_W    = DEF_ROI_W,
    parameter int POOL     = DEF_POOL,
    parameter int POOL_THR = DEF_POOL_THR,
    parameter int PX_W     = $clog2(DEF_ROI_W),
    parameter int LN_W     = $clog2(DEF_ROI_H)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            vld_i,
    input  logic            bin_data_i,
    input  logic [PX_W-1:0] px_i,
    input  logic [LN_W-1:0] ln_i,
    output logic            wr_en_o,
    output logic            wr_data_o
);

    localparam int NBC    = ROI_W / POOL;
    localparam int AW     = acc_width(POOL);
    localparam int LOG_P  = $clog2(POOL);
    localparam logic [AW-1:0] THR = AW'(POOL_THR);

    logic [AW-1:0]         acc_q [NBC];
    logic [PX_W-LOG_P-1:0] bc;
    logic [LOG_P-1:0]      px_lo, ln_lo;
    logic                  blk_first, blk_last;
    logic [AW-1:0]         base, sum_d;
    logic                  wr_en_q, wr_data_q;

    // POOL is a power of two, so block column and in-block offsets are bit slices.
    assign bc        = px_i[PX_W-1:LOG_P];
    assign px_lo     = px_i[LOG_P-1:0];
    assign ln_lo     = ln_i[LOG_P-1:0];
    assign blk_first = (px_lo == '0) && (ln_lo == '0);
    assign blk_last  = (&px_lo) && (&ln_lo);

    // First pixel of a block restarts the count; the threshold compare sees
    // the sum including the current pixel, before it is stored.
    assign base  = blk_first ? '0 : acc_q[bc];
    assign sum_d = base + AW'(bin_data_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NBC; i++) acc_q[i] <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 1'b0;
        end else begin
            wr_en_q <= vld_i && blk_last;
            if (vld_i) acc_q[bc] <= sum_d;
            if (vld_i && blk_last) wr_data_q <= (sum_d >= THR);
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: rtl/roi_capture_ctrl.sv
// roi_capture_ctrl: single-frame capture sequencer for the pooled binary ROI.
// Arms on cap_req, waits for a camera_vs falling edge, pools the bin_data
// stream POOLxPOOL by majority threshold and writes the result row-major
// into the CNN input RAM, then holds cap_done until cap_ack.
// Ports:
//   camera_pclk, s_rst_n       : clock, synchronous active-low reset
//   camera_vs                  : vertical sync, high during blanking
//   bin_data, bin_data_vld     : binarized ROI pixel stream
//   cap_req, cap_ack           : CNN handshake
//   cap_busy, cap_done, cap_err: status (cap_err is a one-cycle short-frame pulse)
//   wr_en, wr_addr, wr_data    : CNN input RAM write port
module roi_capture_ctrl
    import roi_cap_pkg::*;
#(
    parameter int ROI_W    = DEF_ROI_W,
    parameter int ROI_H    = DEF_ROI_H,
    parameter int POOL     = DEF_POOL,
    parameter int POOL_THR = DEF_POOL_THR,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              camera_pclk,
    input  logic              s_rst_n,
    input  logic              camera_vs,
    input  logic              bin_data,
    input  logic              bin_data_vld,
    input  logic              cap_req,
    input  logic              cap_ack,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              cap_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data
);

    localparam int PX_W = $clog2(ROI_W);
    localparam int LN_W = $clog2(ROI_H);

    cap_state_e        state_q;
    logic              vs_q;
    logic [PX_W-1:0]   px_q;
    logic [LN_W-1:0]   ln_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              last_q;    // final block written this cycle
    logic              cap_err_q;

    logic frame_start, frame_end, final_px, abort, pool_vld;
    logic pool_wr_en, pool_wr_data;

    assign frame_start = vs_q && !camera_vs;
    assign frame_end   = !vs_q && camera_vs;
    assign final_px    = bin_data_vld && (px_q == PX_W'(ROI_W - 1))
                                      && (ln_q == LN_W'(ROI_H - 1));
    // A frame end coinciding with the last pixel still completes the capture.
    assign abort       = frame_end && !final_px;
    // Suppressing the pixel on abort keeps a half-finished block from
    // producing a write after the return to ARM.
    assign pool_vld    = (state_q == CAPTURE) && bin_data_vld && !last_q && !abort;

    roi_pool_acc #(
        .ROI_W    (ROI_W),
        .POOL     (POOL),
        .POOL_THR (POOL_THR),
        .PX_W     (PX_W),
        .LN_W     (LN_W)
    ) u_pool (
        .clk        (camera_pclk),
        .rst_n      (s_rst_n),
        .vld_i      (pool_vld),
        .bin_data_i (bin_data),
        .px_i       (px_q),
        .ln_i       (ln_q),
        .wr_en_o    (pool_wr_en),
        .wr_data_o  (pool_wr_data)
    );

    always_ff @(posedge camera_pclk) begin
        if (!s_rst_n) begin
            state_q   <= IDLE;
            vs_q      <= 1'b0;
            px_q      <= '0;
            ln_q      <= '0;
            wr_addr_q <= '0;
            last_q    <= 1'b0;
            cap_err_q <= 1'b0;
        end else begin
            vs_q      <= camera_vs;
            cap_err_q <= 1'b0;
            last_q    <= 1'b0;
            if (pool_wr_en) wr_addr_q <= wr_addr_q + 1'b1;
            unique case (state_q)
                IDLE: if (cap_req) state_q <= ARM;
                ARM: begin
                    if (frame_start) begin
                        px_q      <= '0;
                        ln_q      <= '0;
                        wr_addr_q <= '0;
                        state_q   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (last_q) begin
                        // final write is on the port this cycle
                        state_q <= DONE;
                    end else if (abort) begin
                        cap_err_q <= 1'b1;
                        state_q   <= ARM;
                    end else if (pool_vld) begin
                        last_q <= final_px;
                        if (px_q == PX_W'(ROI_W - 1)) begin
                            px_q <= '0;
                            ln_q <= (ln_q == LN_W'(ROI_H - 1)) ? '0 : ln_q + 1'b1;
                        end else begin
                            px_q <= px_q + 1'b1;
                        end
                    end
                end
                DONE: if (cap_ack) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cap_busy = (state_q == ARM) || (state_q == CAPTURE);
    assign cap_done = (state_q == DONE);
    assign cap_err  = cap_err_q;
    assign wr_en    = pool_wr_en;
    assign wr_data  = pool_wr_data;
    assign wr_addr  = wr_addr_q;

endmodule

// File: tb/tb_roi_capture_ctrl.sv
// Scoreboard bench: stimulus pushes expected {addr,data} writes; a monitor
// pops and compares on every wr_en. A second instance with POOL_THR = 16
// shares the stimulus to cover the higher threshold.
module tb_roi_capture_ctrl;

    logic clk = 1'b0;
    logic s_rst_n, camera_vs, bin_data, bin_data_vld, cap_req, cap_ack;
    logic cap_busy, cap_done, cap_err, wr_en, wr_data;
    logic [9:0] wr_addr;
    logic b_busy, b_done, b_err, b_wr_en, b_wr_data;
    logic [9:0] b_wr_addr;

    always #5 clk = ~clk;

    roi_capture_ctrl dut (
        .camera_pclk(clk), .s_rst_n(s_rst_n), .camera_vs(camera_vs),
        .bin_data(bin_data), .bin_data_vld(bin_data_vld),
        .cap_req(cap_req), .cap_ack(cap_ack),
        .cap_busy(cap_busy), .cap_done(cap_done), .cap_err(cap_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    roi_capture_ctrl #(.POOL_THR(16)) dut16 (
        .camera_pclk(clk), .s_rst_n(s_rst_n), .camera_vs(camera_vs),
        .bin_data(bin_data), .bin_data_vld(bin_data_vld),
        .cap_req(cap_req), .cap_ack(cap_ack),
        .cap_busy(b_busy), .cap_done(b_done), .cap_err(b_err),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
    );

    logic [10:0] q8[$];
    logic [10:0] q16[$];
    int checks = 0, errors = 0;
    int cyc = 0, wr_cnt = 0, busy_cyc = 0, done_cyc = 0, err_cyc = 0;
    int last_wr_cyc = -100, err_run = 0;
    logic done_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic int outs();
        return int'({b_busy, b_done, b_err, b_wr_en, b_wr_data, b_wr_addr,
                     cap_busy, cap_done, cap_err, wr_en, wr_data, wr_addr});
    endfunction

    // Stimulus pixel patterns: 0 all zero, 1 all one, 2 threshold blocks
    // (block0 8 ones, block1 7, block2 16, block3 15, rest zero).
    function automatic logic pix(input int pat, input int ln, input int px);
        int k;
        if (pat == 1) return 1'b1;
        if (pat == 0 || ln >= 4 || px >= 16) return 1'b0;
        k = (ln % 4) * 4 + (px % 4);
        case (px / 4)
            0: return k < 8;
            1: return k < 7;
            2: return 1'b1;
            default: return k < 15;
        endcase
    endfunction

    // Hand-derived pooled results for each pattern and threshold.
    function automatic logic exp_bit(input int pat, input int addr, input bit thr16);
        if (pat == 1) return 1'b1;
        if (pat == 0) return 1'b0;
        if (thr16) return addr == 2;
        return (addr == 0) || (addr == 2) || (addr == 3);
    endfunction

    task automatic push_rows(input int pat, input int rows);
        for (int a = 0; a < rows * 28; a++) begin
            q8.push_back({10'(a), exp_bit(pat, a, 1'b0)});
            q16.push_back({10'(a), exp_bit(pat, a, 1'b1)});
        end
    endtask

    task automatic frame(input int pat, input int nlines, input int req_line, input int rst_line);
        camera_vs = 1'b1; repeat (6) step();
        camera_vs = 1'b0; repeat (3) step();
        for (int ln = 0; ln < nlines; ln++) begin
            if (ln == req_line) cap_req = 1'b1;
            if (ln == rst_line) begin
                s_rst_n = 1'b0; step();
                chk("rst_mid_outs", outs(), 0);
                chk("rst_mid_q8_drained", q8.size(), 0);
                s_rst_n = 1'b1;
            end
            for (int px = 0; px < 112; px++) begin
                bin_data = pix(pat, ln, px); bin_data_vld = 1'b1; step();
                if (ln == 5 && px == 50) begin
                    // vld gap carrying junk data
                    bin_data_vld = 1'b0; bin_data = 1'b1; repeat (2) step();
                end
            end
            bin_data_vld = 1'b0; bin_data = 1'b0; repeat (2) step();
        end
        repeat (3) step();
    endtask

    task automatic finish_cap(input bit toggle_req);
        int n = 0;
        int w0;
        while (!cap_done && n < 2000) begin step(); n++; end
        chk("done_seen", int'(cap_done), 1);
        chk("q8_empty", q8.size(), 0);
        chk("q16_empty", q16.size(), 0);
        chk("busy_in_done", int'(cap_busy), 0);
        if (toggle_req) begin
            w0 = wr_cnt;
            for (int i = 0; i < 4; i++) begin cap_req = ~cap_req; repeat (5) step(); end
            chk("done_req_no_wr", wr_cnt - w0, 0);
            chk("done_held", int'(cap_done), 1);
        end
        cap_req = 1'b0;
        cap_ack = 1'b1; step();
        cap_ack = 1'b0;
        @(negedge clk);
        chk("ack_clears_done", int'({cap_busy, cap_done}), 0);
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [10:0] e;
        cyc++;
        if (wr_en) begin
            wr_cnt++;
            if (q8.size() == 0) chk("unexpected_wr", int'(wr_addr), -1);
            else begin
                e = q8.pop_front();
                chk("wr_addr", int'(wr_addr), int'(e[10:1]));
                chk("wr_data", int'(wr_data), int'(e[0]));
            end
            if (wr_addr == 10'd783) last_wr_cyc = cyc;
        end
        if (b_wr_en) begin
            if (q16.size() == 0) chk("unexpected_wr16", int'(b_wr_addr), -1);
            else begin
                e = q16.pop_front();
                chk("wr_addr16", int'(b_wr_addr), int'(e[10:1]));
                chk("wr_data16", int'(b_wr_data), int'(e[0]));
            end
        end
        if (cap_done && !done_prev) chk("done_latency", cyc - last_wr_cyc, 1);
        done_prev = cap_done;
        if (cap_busy) busy_cyc++;
        if (cap_done) done_cyc++;
        if (cap_err) begin
            err_cyc++;
            err_run++;
            chk("err_in_arm", int'({cap_busy, cap_done}), 2);
        end else if (err_run != 0) begin
            chk("err_width", err_run, 1);
            err_run = 0;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int b0, d0, w0, e0;
        s_rst_n = 1'b0; camera_vs = 1'b1; bin_data = 1'b0; bin_data_vld = 1'b0;
        cap_req = 1'b0; cap_ack = 1'b0;
        repeat (3) step();
        chk("reset_outs", outs(), 0);
        s_rst_n = 1'b1;
        repeat (2) step();

        // Frames with no request: nothing happens.
        b0 = busy_cyc; d0 = done_cyc; w0 = wr_cnt;
        frame(1, 8, -1, -1);
        frame(1, 8, -1, -1);
        chk("idle_wr", wr_cnt - w0, 0);
        chk("idle_busy", busy_cyc - b0, 0);
        chk("idle_done", done_cyc - d0, 0);

        // Full all-ones capture; then cap_req toggling in DONE.
        cap_req = 1'b1;
        w0 = wr_cnt;
        push_rows(1, 28);
        frame(1, 112, -1, -1);
        finish_cap(1'b1);
        chk("full_wr_count", wr_cnt - w0, 784);

        // Request mid-frame at line 50: that frame is skipped, next one uses
        // the threshold pattern.
        frame(1, 60, 50, -1);
        chk("midreq_busy", int'(cap_busy), 1);
        push_rows(2, 28);
        frame(2, 112, -1, -1);
        finish_cap(1'b0);

        // Short frame: 60 lines -> 15 block rows then cap_err, retry.
        cap_req = 1'b1;
        e0 = err_cyc; d0 = done_cyc;
        push_rows(1, 15);
        frame(1, 60, -1, -1);
        camera_vs = 1'b1; repeat (3) step();
        chk("short_err_cnt", err_cyc - e0, 1);
        chk("short_no_done", done_cyc - d0, 0);
        chk("short_back_arm", int'(cap_busy), 1);
        push_rows(1, 28);
        frame(1, 112, -1, -1);
        finish_cap(1'b0);

        // Reset at line 40 mid-capture, then a clean full capture.
        cap_req = 1'b1;
        push_rows(1, 10);
        frame(1, 60, -1, 40);
        push_rows(1, 28);
        w0 = wr_cnt;
        frame(1, 112, -1, -1);
        finish_cap(1'b0);
        chk("post_rst_wr_count", wr_cnt - w0, 784);

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
